// File: rtl/aes128_pipeline_encrypt.sv
// ---------------------------------------------------------------------------
// aes128_pipeline_encrypt
//
// Fully unrolled AES-128 encryption datapath (FIPS-197). A new plaintext and
// cipher key may enter on every rising edge. The round keys are expanded
// stage by stage alongside the data, so consecutive blocks may use unrelated
// keys. There is no handshake. The ciphertext for the block sampled on edge E
// is on data_out after edge E+10, which is 11 edges counting the sampling edge.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset; clears every pipeline register
//   data_in   128-bit plaintext, byte 0 in [127:120], state filled column-major
//   key       128-bit cipher key for the block on data_in, byte 0 in [127:120]
//   data_out  128-bit registered ciphertext, byte 0 in [127:120]
// ---------------------------------------------------------------------------
module aes128_pipeline_encrypt (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic [127:0] data_out
);

    localparam int NUM_ROUNDS = 10;

    // Forward S-box. SBOX[0] is the leftmost byte of the first row.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants; RCON[r] is used to produce the round-r key.
    localparam logic [1:10][7:0] RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

    // -----------------------------------------------------------------------
    // Round primitives
    // -----------------------------------------------------------------------
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // The state is rotated a byte at a time so every byte passes through the
    // top slice; the byte order of the result matches the input.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] src;
        logic [127:0] res;
        src = s;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            res = {res[119:0], sbox(src[127:120])};
            src = {src[119:0], 8'h00};
        end
        return res;
    endfunction

    // Row r of the state is rotated left by r columns. Output byte (r + 4c)
    // takes input byte (r + 4((c + r) mod 4)).
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        return {s[127:120], s[87:80],   s[47:40],   s[7:0],
                s[95:88],   s[55:48],   s[15:8],    s[103:96],
                s[63:56],   s[23:16],   s[111:104], s[71:64],
                s[31:24],   s[119:112], s[79:72],   s[39:32]};
    endfunction

    // Multiplication by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column times the fixed matrix {02 03 01 01} (rotated per row);
    // 03*a is formed as xtime(a) ^ a.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]),  mix_column(s[31:0])};
    endfunction

    // Next round key from the previous one: the last word is rotated,
    // substituted and salted with the round constant, then folded forward
    // through the four words.
    function automatic logic [127:0] key_expand(input logic [127:0] w,
                                                input logic [7:0]   rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({w[23:0], w[31:24]}) ^ {rc, 24'h0};
        w0 = w[127:96] ^ t;
        w1 = w[95:64]  ^ w0;
        w2 = w[63:32]  ^ w1;
        w3 = w[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // -----------------------------------------------------------------------
    // Pipeline: stage 0 holds the whitened input and the cipher key, stage r
    // holds the state after round r together with round key r.
    // -----------------------------------------------------------------------
    for (genvar r = 0; r < NUM_ROUNDS; r++) begin : g_stage
        logic [127:0] state_q, state_d;
        logic [127:0] rk_q, rk_d;

        if (r == 0) begin : g_first
            assign rk_d    = key;
            assign state_d = data_in ^ key;
        end else begin : g_round
            assign rk_d    = key_expand(g_stage[r-1].rk_q, RCON[r]);
            assign state_d = mix_columns(shift_rows(sub_bytes(g_stage[r-1].state_q)))
                             ^ rk_d;
        end

        // NOTE: these are ordinary pipeline flops, not a memory, so clearing
        // them on reset is cheap and keeps every output cycle deterministic;
        // non-blocking assignments let all stages sample the old values of
        // their neighbours on the same edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= '0;
                rk_q    <= '0;
            end else begin
                state_q <= state_d;
                rk_q    <= rk_d;
            end
        end
    end

    // Final round: no MixColumns.
    logic [127:0] data_out_q, data_out_d;

    assign data_out_d = shift_rows(sub_bytes(g_stage[NUM_ROUNDS-1].state_q))
                        ^ key_expand(g_stage[NUM_ROUNDS-1].rk_q, RCON[NUM_ROUNDS]);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_aes128_pipeline_encrypt.sv
// ---------------------------------------------------------------------------
// tb_aes128_pipeline_encrypt
//
// Bench for the pipelined AES-128 encryptor. The reference model builds the
// S-box from GF(2^8) inversion plus the affine map, runs the full FIPS-197
// key schedule on a 4x4 byte state, and predicts data_out from a history of
// what was sampled on each edge.
// ---------------------------------------------------------------------------
module tb_aes128_pipeline_encrypt;

    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] data_in;
    logic [127:0] key;
    logic [127:0] data_out;

    int errors = 0;
    int checks = 0;

    aes128_pipeline_encrypt dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .key      (key),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    bit [7:0] sbox_t [256];

    function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
        bit [8:0] aa;
        bit [7:0] p;
        aa = {1'b0, a};
        p  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa ^= 9'h11b;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            bit [7:0] inv;
            bit [7:0] b;
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, x[7:0]);
            end
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x] = b;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt,
                                             input logic [127:0] k);
        bit [7:0]     st  [4][4];
        bit [7:0]     tmp [4][4];
        bit [31:0]    w   [44];
        bit [31:0]    t;
        bit [7:0]     rc;
        bit [7:0]     a0, a1, a2, a3;
        logic [127:0] ct;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t ^= {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int round = 1; round <= 10; round++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    tmp[r][c] = sbox_t[st[r][(c + r) % 4]];
            for (int c = 0; c < 4; c++) begin
                if (round < 10) begin
                    a0 = tmp[0][c]; a1 = tmp[1][c]; a2 = tmp[2][c]; a3 = tmp[3][c];
                    st[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) st[r][c] = tmp[r][c];
                end
                for (int r = 0; r < 4; r++) st[r][c] ^= w[4*round+c][31-8*r -: 8];
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                ct[127-8*(4*c+r) -: 8] = st[r][c];
        return ct;
    endfunction

    // What each edge sampled. A reset edge leaves stage 0 holding zero data
    // and a zero key, which is the same as sampling data=0, key=0.
    logic [127:0] h_data [$];
    logic [127:0] h_key  [$];
    bit           h_rst  [$];

    // Expected data_out after the most recent edge; returns 0 while the
    // output is still a flush value that carries no defined ciphertext.
    function automatic bit get_exp(output logic [127:0] exp);
        int e;
        exp = '0;
        e = h_rst.size() - 1;
        if (h_rst[e]) return 1'b1;
        if (e < 10) return 1'b0;
        for (int j = e - 9; j < e; j++) if (h_rst[j]) return 1'b0;
        exp = aes_enc(h_data[e-10], h_key[e-10]);
        return 1'b1;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Records the inputs about to be sampled, then lets one edge pass and
    // settles 1 ns past it before anything is observed or driven.
    task automatic tick();
        h_data.push_back(rst ? 128'h0 : data_in);
        h_key.push_back(rst ? 128'h0 : key);
        h_rst.push_back(rst);
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = rand128();
            key     = rand128();
            tick();
            checks++;
            if (data_out !== 128'h0) begin
                errors++;
                $display("FAIL reset_clear cycle %0d: got %h expected 0", i, data_out);
            end
        end
    endtask

    task automatic run_kat(input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] ct, input string name);
        rst     = 1'b0;
        data_in = pt;
        key     = k;
        for (int e = 1; e <= 13; e++) begin
            tick();
            checks++;
            if (e <= 10 && data_out === ct) begin
                errors++;
                $display("FAIL %s_early edge %0d: got %h before latency elapsed", name, e, data_out);
            end else if (e > 10 && data_out !== ct) begin
                errors++;
                $display("FAIL %s edge %0d: got %h expected %h", name, e, data_out, ct);
            end
        end
    endtask

    task automatic test_known_answers();
        run_kat(P1, K1, C1, "kat_fips_c1");
        run_kat(P2, K2, C2, "kat_fips_b");
        run_kat(128'h0, 128'h0, C0, "kat_zero");
    endtask

    task automatic test_latency();
        logic [127:0] pa, ka, pb, kb, ea, eb;
        pa = rand128(); ka = rand128();
        pb = rand128(); kb = rand128();
        ea = aes_enc(pa, ka);
        eb = aes_enc(pb, kb);
        rst = 1'b0;
        data_in = pa;
        key     = ka;
        repeat (11) tick();
        checks++;
        if (data_out !== ea) begin
            errors++;
            $display("FAIL latency_settle: got %h expected %h", data_out, ea);
        end
        data_in = pb;
        key     = kb;
        for (int e = 1; e <= 11; e++) begin
            tick();
            checks++;
            if (e < 11 && data_out !== ea) begin
                errors++;
                $display("FAIL latency_hold edge %0d: got %h expected %h", e, data_out, ea);
            end else if (e == 11 && data_out !== eb) begin
                errors++;
                $display("FAIL latency_arrive edge %0d: got %h expected %h", e, data_out, eb);
            end
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            data_in = (i % 2 == 0) ? P1 : P2;
            key     = (i % 2 == 0) ? K1 : K2;
            tick();
            if (i >= 10) begin
                checks++;
                if (data_out !== ((i % 2 == 0) ? C1 : C2)) begin
                    errors++;
                    $display("FAIL back_to_back cycle %0d: got %h expected %h",
                             i, data_out, (i % 2 == 0) ? C1 : C2);
                end
            end
        end
    endtask

    task automatic test_random_stream();
        logic [127:0] exp;
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            data_in = rand128();
            key     = (i % 3 == 0) ? K2 : rand128();
            tick();
            if (get_exp(exp)) begin
                checks++;
                if (data_out !== exp) begin
                    errors++;
                    $display("FAIL random_stream cycle %0d: got %h expected %h", i, data_out, exp);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        rst     = 1'b0;
        data_in = P1;
        key     = K1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (data_out !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset_clear: got %h expected 0", data_out);
        end
        rst = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e == 10) begin
                // The zeroed stages drain out as the encryption of zeros.
                checks++;
                if (data_out !== C0) begin
                    errors++;
                    $display("FAIL mid_reset_flush edge %0d: got %h expected %h", e, data_out, C0);
                end
            end else if (e >= 11) begin
                checks++;
                if (data_out !== C1) begin
                    errors++;
                    $display("FAIL mid_reset_recover edge %0d: got %h expected %h", e, data_out, C1);
                end
            end
        end
    endtask

    task automatic test_random_resets();
        logic [127:0] exp;
        for (int i = 0; i < 250; i++) begin
            rst     = ($urandom_range(0, 24) == 0);
            data_in = rand128();
            key     = rand128();
            tick();
            if (get_exp(exp)) begin
                checks++;
                if (data_out !== exp) begin
                    errors++;
                    $display("FAIL random_resets cycle %0d rst=%0b: got %h expected %h",
                             i, rst, data_out, exp);
                end
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        data_in = '0;
        key     = '0;
        build_sbox();
        test_reset();
        test_known_answers();
        test_latency();
        test_back_to_back();
        test_random_stream();
        test_mid_reset();
        test_random_resets();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
